// File: rtl/hilo_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// hilo_div_unit_pkg
// Shared definitions for the HI/LO register unit: operation codes, divider
// FSM states, step count and a small op-decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package hilo_div_unit_pkg;

    // Restoring division takes one step per operand bit.
    localparam int DIV_STEPS  = 32;
    localparam int HILO_CNT_W = 6;

    // Operation codes presented on op; codes 6 and 7 behave as NONE.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MULW = 3'd1,
        OP_DIV  = 3'd2,
        OP_DIVU = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5
    } hiloOp_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } hiloState_e;

    // True for the two codes that launch the multi-cycle divider.
    function automatic logic isDivOp(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_div_unit_if
// Bundles the operation request from the pipeline and the HI/LO / status
// results returned by the unit.
//   master : pipeline side (drives op_valid, op, a, b, alu_r, alu_r2)
//   slave  : HI/LO unit side (drives hi, lo, stall, busy, div_done, div_zero)
// ---------------------------------------------------------------------------
interface hilo_div_unit_if
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH-1:0] alu_r2;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall;
    logic             busy;
    logic             div_done;
    logic             div_zero;

    modport master (
        output op_valid, op, a, b, alu_r, alu_r2,
        input  hi, lo, stall, busy, div_done, div_zero
    );

    modport slave (
        input  op_valid, op, a, b, alu_r, alu_r2,
        output hi, lo, stall, busy, div_done, div_zero
    );
endinterface

// File: rtl/hilo_div_unit_div_step.sv
// ---------------------------------------------------------------------------
// hilo_div_unit_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i / rem_o : partial remainder (WIDTH+1 bits) before / after the step
//   q_i   / q_o   : dividend-shifting-into-quotient register before / after
//   d_i           : divisor magnitude
// ---------------------------------------------------------------------------
module hilo_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH+1:0] remShift;

    // Bring the next dividend bit into the remainder, then subtract the
    // divisor if it fits. The shifted remainder never really reaches bit
    // WIDTH+1, so the subtraction is done on the lower WIDTH+1 bits only.
    always_comb begin
        remShift = {rem_i, q_i[WIDTH-1]};
        if (remShift >= {2'b00, d_i}) begin
            rem_o = remShift[WIDTH:0] - {1'b0, d_i};
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = remShift[WIDTH:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/hilo_div_unit.sv
// ---------------------------------------------------------------------------
// hilo_div_unit
// HI/LO register unit behind the ALU: captures multu products, executes
// div/divu with a 32-step restoring divider and holds HI/LO for mfhi/mflo.
// The pipeline is stalled for the whole division.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts a division in flight)
//   bus  : slave side of hilo_div_unit_if (op request in, HI/LO/status out)
// ---------------------------------------------------------------------------
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS,
    parameter int CNT_W = HILO_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    hilo_div_unit_if.slave bus
);
    hiloState_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] divisor_q;
    logic             negQuot_q;
    logic             negRem_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             divDone_q;
    logic             divZero_q;

    logic             accept;
    logic             divSigned;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   remStep;
    logic [WIDTH-1:0] quotStep;

    hilo_div_unit_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .q_i   (quot_q),
        .d_i   (divisor_q),
        .rem_o (remStep),
        .q_o   (quotStep)
    );

    // Operand conditioning for the accept edge: DIV works on magnitudes and
    // remembers the signs, DIVU passes the raw values with signs forced off.
    always_comb begin
        accept    = bus.op_valid && (state_q == S_IDLE);
        divSigned = (bus.op == OP_DIV);
        aNeg      = divSigned & bus.a[WIDTH-1];
        bNeg      = divSigned & bus.b[WIDTH-1];
        aMag      = aNeg ? -bus.a : bus.a;
        bMag      = bNeg ? -bus.b : bus.b;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a divide runs DIV_STEPS edges in RUN, then one FIXUP
    // edge that publishes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && isDivOp(bus.op)) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIXUP;
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stall also covers the accept cycle itself so the
    // dividing instruction is held from the moment it is presented.
    always_comb begin
        bus.stall    = (state_q != S_IDLE) ||
                       (bus.op_valid && (state_q == S_IDLE) && isDivOp(bus.op));
        bus.busy     = (state_q != S_IDLE);
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.div_done = divDone_q;
        bus.div_zero = divZero_q;
    end

    // Datapath: single-cycle HI/LO writes, divider setup/iteration and the
    // sign fixup. A zero divisor falls out of the restoring loop as an
    // all-ones quotient and a remainder equal to |a|; the remainder sign
    // fixup then restores the original a, so only LO needs forcing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divDone_q <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            divDone_q <= 1'b0;
            divZero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULW: begin
                                hi_q <= bus.alu_r2;
                                lo_q <= bus.alu_r;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            OP_DIV, OP_DIVU: begin
                                quot_q    <= aMag;
                                divisor_q <= bMag;
                                negQuot_q <= aNeg ^ bNeg;
                                negRem_q  <= aNeg;
                                zero_q    <= (bus.b == '0);
                                rem_q     <= '0;
                                cnt_q     <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    rem_q  <= remStep;
                    quot_q <= quotStep;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                S_FIXUP: begin
                    lo_q      <= zero_q ? '1 : (negQuot_q ? -quot_q : quot_q);
                    hi_q      <= negRem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    divDone_q <= 1'b1;
                    divZero_q <= zero_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_unit
// Self-checking bench for hilo_div_unit: directed single-cycle and division
// vector tables, hand-written reset/hold sequences, and randomized ops
// compared against an arithmetic reference model of HI/LO.
// ---------------------------------------------------------------------------
module tb_hilo_div_unit;

    localparam logic [2:0] OPC_NONE = 3'd0;
    localparam logic [2:0] OPC_MULW = 3'd1;
    localparam logic [2:0] OPC_DIV  = 3'd2;
    localparam logic [2:0] OPC_DIVU = 3'd3;
    localparam logic [2:0] OPC_MTHI = 3'd4;
    localparam logic [2:0] OPC_MTLO = 3'd5;

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] aluR;
        logic [31:0] aluR2;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } singleVec_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expZero;
    } divVec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    singleVec_t singleVecs[8];
    divVec_t    divVecs[8];

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference division from plain integer arithmetic.
    function automatic void refDiv(input logic isSigned, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (isSigned) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present one single-cycle (or ignored) op for one edge and check result.
    task automatic applyStimulus(input logic vld, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] aluR, input logic [31:0] aluR2,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        bus.op_valid = vld;
        bus.op       = op;
        bus.a        = a;
        bus.b        = 32'h0000_0003;
        bus.alu_r    = aluR;
        bus.alu_r2   = aluR2;
        #1;
        checkOutput("single stall", 32'(bus.stall), 32'd0);
        nextCycle();
        bus.op_valid = 1'b0;
        #1;
        checkOutput("single hi", bus.hi, expHi);
        checkOutput("single lo", bus.lo, expLo);
        checkOutput("single busy", 32'(bus.busy), 32'd0);
    endtask

    // Run one division from IDLE to completion and check stall/busy length,
    // HI/LO hold during the run, the result and the done/zero pulse.
    task automatic runDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expHi, input logic [31:0] expLo, input logic expZero);
        int   stallCnt;
        int   busyCnt;
        logic holdOk;
        logic done;
        stallCnt = 0;
        busyCnt  = 0;
        holdOk   = 1'b1;
        done     = 1'b0;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (bus.stall) begin
                stallCnt++;
                if (bus.busy) busyCnt++;
                if (bus.hi !== modelHi || bus.lo !== modelLo || bus.div_done !== 1'b0) holdOk = 1'b0;
                nextCycle();
                bus.op_valid = 1'b0;
                #1;
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("div stall cycles", 32'(stallCnt), 32'd34);
        checkOutput("div busy cycles", 32'(busyCnt), 32'd33);
        checkOutput("div hold hi/lo", 32'(holdOk), 32'd1);
        checkOutput("div done pulse", 32'(bus.div_done), 32'd1);
        checkOutput("div zero flag", 32'(bus.div_zero), 32'(expZero));
        checkOutput("div hi", bus.hi, expHi);
        checkOutput("div lo", bus.lo, expLo);
        modelHi = expHi;
        modelLo = expLo;
        nextCycle();
        #1;
        checkOutput("div done clears", 32'(bus.div_done), 32'd0);
        checkOutput("div zero clears", 32'(bus.div_zero), 32'd0);
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] qRef, rRef, av, bv, aluR, aluR2;
        logic [2:0]  opc;
        logic        vld, doneSeen, holdOk, sawActivity;

        checks   = 0;
        failures = 0;
        modelHi  = 32'd0;
        modelLo  = 32'd0;

        singleVecs[0] = '{1'b1, OPC_MULW, 32'h0000_0000, 32'h89ABCDEF, 32'h01234567, 32'h01234567, 32'h89ABCDEF};
        singleVecs[1] = '{1'b1, OPC_MTHI, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h89ABCDEF};
        singleVecs[2] = '{1'b1, OPC_MTLO, 32'hCAFEF00D, 32'h33333333, 32'h44444444, 32'hDEADBEEF, 32'hCAFEF00D};
        singleVecs[3] = '{1'b1, OPC_NONE, 32'h55555555, 32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'hCAFEF00D};
        singleVecs[4] = '{1'b1, 3'd6,     32'h55555555, 32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'hCAFEF00D};
        singleVecs[5] = '{1'b1, 3'd7,     32'h55555555, 32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'hCAFEF00D};
        singleVecs[6] = '{1'b0, OPC_MULW, 32'h55555555, 32'h66666666, 32'h77777777, 32'hDEADBEEF, 32'hCAFEF00D};
        singleVecs[7] = '{1'b1, OPC_MULW, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        divVecs[0] = '{OPC_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        divVecs[1] = '{OPC_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  1'b0};
        divVecs[2] = '{OPC_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h00000000,  32'h80000000,  1'b0};
        divVecs[3] = '{OPC_DIVU, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1'b1};
        divVecs[4] = '{OPC_DIV,  32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  1'b0};
        divVecs[5] = '{OPC_DIVU, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  1'b0};
        divVecs[6] = '{OPC_DIV,  32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  32'hFFFFFFFF,  1'b1};
        divVecs[7] = '{OPC_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h00000000,  1'b0};

        // Power-on reset.
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = OPC_NONE;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.alu_r    = 32'd0;
        bus.alu_r2   = 32'd0;
        #2;
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);
        checkOutput("reset stall", 32'(bus.stall), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset div_done", 32'(bus.div_done), 32'd0);
        checkOutput("reset div_zero", 32'(bus.div_zero), 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Single-cycle op table.
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(singleVecs[i].vld, singleVecs[i].op, singleVecs[i].a,
                          singleVecs[i].aluR, singleVecs[i].aluR2,
                          singleVecs[i].expHi, singleVecs[i].expLo);
        end
        modelHi = 32'hFFFFFFFF;
        modelLo = 32'h00000000;

        // Asynchronous reset between edges clears HI/LO immediately.
        nextCycle();
        applyStimulus(1'b1, OPC_MULW, 32'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset hi", bus.hi, 32'd0);
        checkOutput("async reset lo", bus.lo, 32'd0);
        nextCycle();
        rst = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;

        // Directed division table.
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            runDiv(divVecs[i].op, divVecs[i].a, divVecs[i].b,
                   divVecs[i].expHi, divVecs[i].expLo, divVecs[i].expZero);
        end

        // MTLO held valid during a DIV: ignored until IDLE, then applied.
        nextCycle();
        bus.op_valid = 1'b1;
        bus.op       = OPC_DIV;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        #1;
        checkOutput("held accept stall", 32'(bus.stall), 32'd1);
        nextCycle();
        bus.op = OPC_MTLO;
        bus.a  = 32'd9;
        #1;
        doneSeen = 1'b0;
        holdOk   = 1'b1;
        for (int cyc = 0; cyc < 60 && !doneSeen; cyc++) begin
            if (bus.div_done) begin
                doneSeen = 1'b1;
            end else begin
                if (bus.lo !== modelLo || bus.hi !== modelHi || bus.stall !== 1'b1) holdOk = 1'b0;
                nextCycle();
                #1;
            end
        end
        checkOutput("held done seen", 32'(doneSeen), 32'd1);
        checkOutput("held hold during run", 32'(holdOk), 32'd1);
        checkOutput("held div lo", bus.lo, 32'd14);
        checkOutput("held div hi", bus.hi, 32'd2);
        nextCycle();
        bus.op_valid = 1'b0;
        #1;
        checkOutput("held mtlo lo", bus.lo, 32'd9);
        checkOutput("held mtlo hi", bus.hi, 32'd2);
        modelHi = 32'd2;
        modelLo = 32'd9;

        // Reset at RUN cycle 10 aborts the division.
        nextCycle();
        bus.op_valid = 1'b1;
        bus.op       = OPC_DIV;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        nextCycle();
        bus.op_valid = 1'b0;
        repeat (10) nextCycle();
        #2;
        checkOutput("abort busy before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort hi", bus.hi, 32'd0);
        checkOutput("abort lo", bus.lo, 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort stall", 32'(bus.stall), 32'd0);
        checkOutput("abort div_done", 32'(bus.div_done), 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        sawActivity = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            nextCycle();
            if (bus.div_done || bus.busy || bus.stall) sawActivity = 1'b1;
        end
        checkOutput("abort no late done", 32'(sawActivity), 32'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;

        // Randomized op stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            opc   = 3'($urandom_range(0, 7));
            vld   = ($urandom_range(0, 4) != 0);
            av    = $urandom;
            aluR  = $urandom;
            aluR2 = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = 32'd0;
                1:       bv = 32'($urandom_range(1, 15));
                2:       bv = $urandom;
                default: bv = 32'hFFFFFFFF - 32'($urandom_range(0, 8));
            endcase
            nextCycle();
            if (vld && (opc == OPC_DIV || opc == OPC_DIVU)) begin
                refDiv(opc == OPC_DIV, av, bv, qRef, rRef);
                runDiv(opc, av, bv, rRef, qRef, bv == 32'd0);
            end else begin
                if (vld) begin
                    case (opc)
                        OPC_MULW: begin
                            modelHi = aluR2;
                            modelLo = aluR;
                        end
                        OPC_MTHI: modelHi = av;
                        OPC_MTLO: modelLo = av;
                        default: ;
                    endcase
                end
                bus.b = bv;
                applyStimulus(vld, opc, av, aluR, aluR2, modelHi, modelLo);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
